// File: rtl/ooo_pkg.sv
// Shared widths and the ROB entry record for the out-of-order back end.
package ooo_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned PHYS_REG_SIZE = 256;
  localparam int unsigned ROB_ENTRY     = 256;
  localparam int unsigned ARCH_REGS     = 32;

  localparam int unsigned PW = $clog2(PHYS_REG_SIZE);
  localparam int unsigned RW = $clog2(ROB_ENTRY);
  localparam int unsigned AW = $clog2(ARCH_REGS);

  typedef struct packed {
    logic            has_dest;
    logic [AW-1:0]   arch_reg;
    logic [PW-1:0]   phys_reg;
    logic [PW-1:0]   old_phys_reg;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] val;
  } rob_entry_t;

endpackage

// File: rtl/rob_storage.sv
// ROB payload array: allocate write, completion value write, async reads at head
// and at the completing entry (for the tag check).
module rob_storage
  import ooo_pkg::*;
(
  input  logic            clk,
  input  logic            alloc_we,
  input  logic [RW-1:0]   alloc_idx,
  input  rob_entry_t      alloc_data,
  input  logic            cmpl_we,
  input  logic [RW-1:0]   cmpl_idx,
  input  logic [XLEN-1:0] cmpl_val,
  input  logic [RW-1:0]   head_idx,
  output rob_entry_t      head_data,
  output logic [PW-1:0]   cmpl_phys
);

  rob_entry_t mem_q [ROB_ENTRY];

  // The two write ports never target the same index: a completion to the
  // entry being allocated is rejected by the top as unallocated.
  always_ff @(posedge clk) begin
    if (alloc_we) mem_q[alloc_idx] <= alloc_data;
    if (cmpl_we)  mem_q[cmpl_idx].val <= cmpl_val;
  end

  assign head_data = mem_q[head_idx];
  assign cmpl_phys = mem_q[cmpl_idx].phys_reg;

endmodule

// File: rtl/rob_retire_buffer.sv
// Reorder buffer: in-order allocate at tail, out-of-order completion from the ring tap,
// in-order single-entry retire at head, synchronous flush.
module rob_retire_buffer
  import ooo_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_valid,
  output logic            alloc_ready,
  output logic [RW-1:0]   alloc_entry,
  input  logic            alloc_has_dest,
  input  logic [AW-1:0]   alloc_arch_reg,
  input  logic [PW-1:0]   alloc_phys_reg,
  input  logic [PW-1:0]   alloc_old_phys_reg,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            cmpl_valid,
  input  logic [RW-1:0]   cmpl_rob_entry,
  input  logic [PW-1:0]   cmpl_update_reg,
  input  logic [XLEN-1:0] cmpl_update_val,
  input  logic            flush_valid,
  output logic            retire_valid,
  output logic            retire_has_dest,
  output logic [AW-1:0]   retire_arch_reg,
  output logic [PW-1:0]   retire_phys_reg,
  output logic [PW-1:0]   retire_old_phys_reg,
  output logic [XLEN-1:0] retire_pc,
  output logic [XLEN-1:0] retire_val,
  output logic [RW:0]     occupancy,
  output logic            empty,
  output logic            full,
  output logic            cmpl_err
);

  logic [RW:0]          head_q, head_d, tail_q, tail_d;
  logic [ROB_ENTRY-1:0] valid_q, valid_d, done_q, done_d;
  logic                 cmpl_err_q, cmpl_err_d;
  logic                 retire_valid_q, retire_valid_d;
  rob_entry_t           retire_q, retire_d;

  logic [RW-1:0] head_idx, tail_idx;
  logic          alloc_fire, cmpl_hit, cmpl_fire, cmpl_bad, retire_fire;
  rob_entry_t    alloc_data, head_data;
  logic [PW-1:0] cmpl_phys;

  assign head_idx = head_q[RW-1:0];
  assign tail_idx = tail_q[RW-1:0];

  assign occupancy   = tail_q - head_q;
  assign empty       = (head_q == tail_q);
  assign full        = (head_idx == tail_idx) && (head_q[RW] != tail_q[RW]);
  assign alloc_ready = !full && !flush_valid;
  assign alloc_entry = tail_idx;
  assign alloc_fire  = alloc_valid && alloc_ready;

  // A same-cycle completion to the tail sees valid=0 there, so it is dropped.
  assign cmpl_hit    = valid_q[cmpl_rob_entry] && !done_q[cmpl_rob_entry] &&
                       (cmpl_phys == cmpl_update_reg);
  assign cmpl_fire   = cmpl_valid && !flush_valid && cmpl_hit;
  assign cmpl_bad    = cmpl_valid && !flush_valid && !cmpl_hit;
  assign retire_fire = !flush_valid && valid_q[head_idx] && done_q[head_idx];

  always_comb begin
    alloc_data              = '0;
    alloc_data.has_dest     = alloc_has_dest;
    alloc_data.arch_reg     = alloc_arch_reg;
    alloc_data.phys_reg     = alloc_phys_reg;
    alloc_data.old_phys_reg = alloc_old_phys_reg;
    alloc_data.pc           = alloc_pc;
  end

  rob_storage u_storage (
    .clk        (clk),
    .alloc_we   (alloc_fire),
    .alloc_idx  (tail_idx),
    .alloc_data (alloc_data),
    .cmpl_we    (cmpl_fire),
    .cmpl_idx   (cmpl_rob_entry),
    .cmpl_val   (cmpl_update_val),
    .head_idx   (head_idx),
    .head_data  (head_data),
    .cmpl_phys  (cmpl_phys)
  );

  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    valid_d        = valid_q;
    done_d         = done_q;
    cmpl_err_d     = cmpl_err_q || cmpl_bad;
    retire_valid_d = retire_fire;
    retire_d       = retire_q;
    if (flush_valid) begin
      head_d  = '0;
      tail_d  = '0;
      valid_d = '0;
      done_d  = '0;
    end else begin
      if (retire_fire) begin
        valid_d[head_idx] = 1'b0;
        head_d            = head_q + 1'b1;
        retire_d          = head_data;
      end
      if (cmpl_fire) done_d[cmpl_rob_entry] = 1'b1;
      if (alloc_fire) begin
        valid_d[tail_idx] = 1'b1;
        done_d[tail_idx]  = 1'b0;
        tail_d            = tail_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      valid_q        <= '0;
      done_q         <= '0;
      cmpl_err_q     <= 1'b0;
      retire_valid_q <= 1'b0;
      retire_q       <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      valid_q        <= valid_d;
      done_q         <= done_d;
      cmpl_err_q     <= cmpl_err_d;
      retire_valid_q <= retire_valid_d;
      retire_q       <= retire_d;
    end
  end

  assign cmpl_err            = cmpl_err_q;
  assign retire_valid        = retire_valid_q;
  assign retire_has_dest     = retire_q.has_dest;
  assign retire_arch_reg     = retire_q.arch_reg;
  assign retire_phys_reg     = retire_q.phys_reg;
  assign retire_old_phys_reg = retire_q.old_phys_reg;
  assign retire_pc           = retire_q.pc;
  assign retire_val          = retire_q.val;

endmodule

// File: tb/tb_rob_retire_buffer.sv
// Self-checking bench for rob_retire_buffer: directed table, corner sequences,
// and randomized traffic against a queue-based program-order model.
module tb_rob_retire_buffer;
  import ooo_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            alloc_valid, alloc_ready;
  logic [RW-1:0]   alloc_entry;
  logic            alloc_has_dest;
  logic [AW-1:0]   alloc_arch_reg;
  logic [PW-1:0]   alloc_phys_reg, alloc_old_phys_reg;
  logic [XLEN-1:0] alloc_pc;
  logic            cmpl_valid;
  logic [RW-1:0]   cmpl_rob_entry;
  logic [PW-1:0]   cmpl_update_reg;
  logic [XLEN-1:0] cmpl_update_val;
  logic            flush_valid;
  logic            retire_valid, retire_has_dest;
  logic [AW-1:0]   retire_arch_reg;
  logic [PW-1:0]   retire_phys_reg, retire_old_phys_reg;
  logic [XLEN-1:0] retire_pc, retire_val;
  logic [RW:0]     occupancy;
  logic            empty, full, cmpl_err;

  always #5 clk = ~clk;

  rob_retire_buffer dut (
    .clk                 (clk),
    .rst                 (rst),
    .alloc_valid         (alloc_valid),
    .alloc_ready         (alloc_ready),
    .alloc_entry         (alloc_entry),
    .alloc_has_dest      (alloc_has_dest),
    .alloc_arch_reg      (alloc_arch_reg),
    .alloc_phys_reg      (alloc_phys_reg),
    .alloc_old_phys_reg  (alloc_old_phys_reg),
    .alloc_pc            (alloc_pc),
    .cmpl_valid          (cmpl_valid),
    .cmpl_rob_entry      (cmpl_rob_entry),
    .cmpl_update_reg     (cmpl_update_reg),
    .cmpl_update_val     (cmpl_update_val),
    .flush_valid         (flush_valid),
    .retire_valid        (retire_valid),
    .retire_has_dest     (retire_has_dest),
    .retire_arch_reg     (retire_arch_reg),
    .retire_phys_reg     (retire_phys_reg),
    .retire_old_phys_reg (retire_old_phys_reg),
    .retire_pc           (retire_pc),
    .retire_val          (retire_val),
    .occupancy           (occupancy),
    .empty               (empty),
    .full                (full),
    .cmpl_err            (cmpl_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: in-flight uops in program order; head is the front of the queue.
  typedef struct {
    int              idx;
    logic            has_dest;
    logic [AW-1:0]   arch;
    logic [PW-1:0]   phys;
    logic [PW-1:0]   old;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] val;
    bit              done;
  } m_ent_t;

  m_ent_t mq[$];
  int     m_tail = 0;
  bit     m_err  = 0;
  bit     m_rv   = 0;
  m_ent_t m_ret;

  task automatic model_edge();
    bit     ret, afire;
    int     k;
    m_ent_t e;
    if (rst) begin
      mq.delete();
      m_tail = 0;
      m_err  = 0;
      m_rv   = 0;
      m_ret  = '{default: 0};
    end else if (flush_valid) begin
      mq.delete();
      m_tail = 0;
      m_rv   = 0;
    end else begin
      ret   = (mq.size() > 0) && mq[0].done;
      afire = alloc_valid && (mq.size() < ROB_ENTRY);
      if (cmpl_valid) begin
        k = -1;
        foreach (mq[i]) if (mq[i].idx == int'(cmpl_rob_entry)) k = i;
        if (k >= 0 && !mq[k].done && mq[k].phys == cmpl_update_reg) begin
          mq[k].done = 1;
          mq[k].val  = cmpl_update_val;
        end else begin
          m_err = 1;
        end
      end
      m_rv = ret;
      if (ret) begin
        m_ret = mq[0];
        void'(mq.pop_front());
      end
      if (afire) begin
        e.idx      = m_tail;
        e.has_dest = alloc_has_dest;
        e.arch     = alloc_arch_reg;
        e.phys     = alloc_phys_reg;
        e.old      = alloc_old_phys_reg;
        e.pc       = alloc_pc;
        e.val      = '0;
        e.done     = 0;
        mq.push_back(e);
        m_tail = (m_tail + 1) % ROB_ENTRY;
      end
    end
  endtask

  task automatic drive_idle();
    rst = 0; alloc_valid = 0; alloc_has_dest = 0; alloc_arch_reg = '0;
    alloc_phys_reg = '0; alloc_old_phys_reg = '0; alloc_pc = '0;
    cmpl_valid = 0; cmpl_rob_entry = '0; cmpl_update_reg = '0; cmpl_update_val = '0;
    flush_valid = 0;
  endtask

  task automatic set_alloc(input int phys, input int old, input int arch, input int pc);
    alloc_valid = 1; alloc_has_dest = 1;
    alloc_phys_reg = PW'(phys); alloc_old_phys_reg = PW'(old);
    alloc_arch_reg = AW'(arch); alloc_pc = XLEN'(pc);
  endtask

  task automatic set_cmpl(input int entry, input int tag, input logic [XLEN-1:0] val);
    cmpl_valid = 1; cmpl_rob_entry = RW'(entry); cmpl_update_reg = PW'(tag);
    cmpl_update_val = val;
  endtask

  // Inputs are already set; check combinational outputs, step model, clock, check state.
  task automatic cycle();
    #1;
    chk("alloc_ready", alloc_ready, (mq.size() < ROB_ENTRY) && !flush_valid);
    chk("alloc_entry", alloc_entry, m_tail);
    model_edge();
    @(posedge clk);
    #1;
    chk("retire_valid", retire_valid, m_rv);
    chk("retire_has_dest", retire_has_dest, m_ret.has_dest);
    chk("retire_arch_reg", retire_arch_reg, m_ret.arch);
    chk("retire_phys_reg", retire_phys_reg, m_ret.phys);
    chk("retire_old_phys_reg", retire_old_phys_reg, m_ret.old);
    chk("retire_pc", retire_pc, m_ret.pc);
    chk("retire_val", retire_val, m_ret.val);
    chk("occupancy", occupancy, mq.size());
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == ROB_ENTRY);
    chk("cmpl_err", cmpl_err, m_err);
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1;
    cycle();
    rst = 0;
    chk("rst_empty", empty, 1);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_occupancy", occupancy, 0);
  endtask

  typedef struct {
    bit              av;
    int              aphys;
    bit              cv;
    int              centry;
    int              creg;
    logic [XLEN-1:0] cval;
    bit              exp_rv;
    logic [XLEN-1:0] exp_val;
    int              exp_occ;
  } vec_t;

  vec_t tbl[9];

  initial begin
    m_ret = '{default: 0};
    tbl[0] = '{av:1, aphys:10, cv:0, centry:0, creg:0,  cval:0,   exp_rv:0, exp_val:0,   exp_occ:1};
    tbl[1] = '{av:1, aphys:11, cv:0, centry:0, creg:0,  cval:0,   exp_rv:0, exp_val:0,   exp_occ:2};
    tbl[2] = '{av:1, aphys:12, cv:0, centry:0, creg:0,  cval:0,   exp_rv:0, exp_val:0,   exp_occ:3};
    tbl[3] = '{av:0, aphys:0,  cv:1, centry:2, creg:12, cval:'hC, exp_rv:0, exp_val:0,   exp_occ:3};
    tbl[4] = '{av:0, aphys:0,  cv:1, centry:0, creg:10, cval:'hA, exp_rv:0, exp_val:0,   exp_occ:3};
    tbl[5] = '{av:0, aphys:0,  cv:1, centry:1, creg:11, cval:'hB, exp_rv:1, exp_val:'hA, exp_occ:2};
    tbl[6] = '{av:0, aphys:0,  cv:0, centry:0, creg:0,  cval:0,   exp_rv:1, exp_val:'hB, exp_occ:1};
    tbl[7] = '{av:0, aphys:0,  cv:0, centry:0, creg:0,  cval:0,   exp_rv:1, exp_val:'hC, exp_occ:0};
    tbl[8] = '{av:0, aphys:0,  cv:0, centry:0, creg:0,  cval:0,   exp_rv:0, exp_val:'hC, exp_occ:0};

    drive_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_edge();
    do_reset();

    // In-order retire of out-of-order completions.
    foreach (tbl[i]) begin
      drive_idle();
      if (tbl[i].av) set_alloc(tbl[i].aphys, tbl[i].aphys + 100, tbl[i].aphys - 9,
                               'h1000 + 4 * i);
      if (tbl[i].cv) set_cmpl(tbl[i].centry, tbl[i].creg, tbl[i].cval);
      cycle();
      chk("tbl_retire_valid", retire_valid, tbl[i].exp_rv);
      chk("tbl_retire_val", retire_val, tbl[i].exp_val);
      chk("tbl_occupancy", occupancy, tbl[i].exp_occ);
      chk("tbl_cmpl_err", cmpl_err, 0);
    end

    // Completion-to-retire latency.
    do_reset();
    drive_idle(); set_alloc(7, 77, 3, 'h40); cycle();
    drive_idle(); set_cmpl(0, 7, 'h99); cycle();
    chk("lat_n1_retire_valid", retire_valid, 0);
    drive_idle(); cycle();
    chk("lat_n2_retire_valid", retire_valid, 1);
    chk("lat_old_phys", retire_old_phys_reg, 77);
    drive_idle(); cycle();

    // Fill, refuse alloc while full even with same-cycle retire, wrap the tail.
    do_reset();
    for (int i = 0; i < ROB_ENTRY; i++) begin
      drive_idle(); set_alloc(i, 255 - i, i % 32, i * 4); cycle();
    end
    drive_idle();
    #1;
    chk("full_flag", full, 1);
    chk("full_alloc_ready", alloc_ready, 0);
    chk("full_alloc_entry", alloc_entry, 0);
    set_cmpl(0, 0, 'h55); cycle();
    drive_idle(); set_alloc(200, 201, 5, 'h800);
    #1;
    chk("full_refuse_ready", alloc_ready, 0);
    cycle();
    chk("full_refuse_occ", occupancy, 255);
    chk("full_retire_val", retire_val, 'h55);
    cycle();
    chk("full_accept_occ", occupancy, 256);
    chk("full_wrap_entry", alloc_entry, 1);

    // Tag mismatch is dropped and sticky.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_idle(); set_alloc(35 + i, i, i, 'h200 + 4 * i); cycle();
    end
    drive_idle(); set_cmpl(5, 99, 'hDEAD); cycle();
    chk("mm_err", cmpl_err, 1);
    drive_idle(); set_cmpl(5, 40, 'h5); cycle();
    chk("mm_err_sticky", cmpl_err, 1);
    for (int i = 0; i < 5; i++) begin
      drive_idle(); set_cmpl(i, 35 + i, XLEN'(i)); cycle();
    end
    drive_idle();
    repeat (4) cycle();
    chk("mm_last_val", retire_val, 'h5);
    chk("mm_last_phys", retire_phys_reg, 40);

    // Flush beats a same-cycle alloc; stale completions flag an error.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_idle(); set_alloc(20 + i, i, i, 'h300 + 4 * i); cycle();
    end
    drive_idle(); set_cmpl(2, 22, 'h22); cycle();
    drive_idle(); set_cmpl(3, 23, 'h23); cycle();
    drive_idle(); set_alloc(50, 51, 1, 'h400); flush_valid = 1;
    #1;
    chk("flush_alloc_ready", alloc_ready, 0);
    cycle();
    chk("flush_occ", occupancy, 0);
    chk("flush_empty", empty, 1);
    chk("flush_rv", retire_valid, 0);
    chk("flush_err_kept", cmpl_err, 0);
    drive_idle(); set_cmpl(1, 21, 'h21); cycle();
    chk("flush_stale_err", cmpl_err, 1);

    // Reset in the middle of a retire burst.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_idle(); set_alloc(60 + i, 70 + i, i, 'h500 + 4 * i); cycle();
    end
    for (int i = 0; i < 3; i++) begin
      drive_idle(); set_cmpl(i, 60 + i, 'hA0 + i); cycle();
    end
    drive_idle(); set_alloc(9, 9, 9, 'h9); rst = 1; cycle();
    drive_idle();
    #1;
    chk("mid_rst_rv", retire_valid, 0);
    chk("mid_rst_val", retire_val, 0);
    chk("mid_rst_pc", retire_pc, 0);
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_entry", alloc_entry, 0);

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      int k;
      drive_idle();
      rst         = ($urandom_range(0, 399) == 0);
      flush_valid = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 9) < ((n / 500) % 2 == 0 ? 8 : 4)) begin
        alloc_valid        = 1;
        alloc_has_dest     = 1'($urandom);
        alloc_arch_reg     = AW'($urandom);
        alloc_phys_reg     = PW'($urandom);
        alloc_old_phys_reg = PW'($urandom);
        alloc_pc           = $urandom;
      end
      if ($urandom_range(0, 1) == 1) begin
        cmpl_valid      = 1;
        cmpl_update_val = $urandom;
        if (mq.size() > 0 && $urandom_range(0, 29) != 0) begin
          k               = $urandom_range(0, mq.size() - 1);
          cmpl_rob_entry  = RW'(mq[k].idx);
          cmpl_update_reg = mq[k].phys;
        end else begin
          cmpl_rob_entry  = RW'($urandom);
          cmpl_update_reg = PW'($urandom);
        end
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
